// File: rtl/mem_dump_reader.sv
// Streams a contiguous block of words from a synchronous RAM read port to a
// valid/ready output, one word at a time, tagging each word with its address.
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ZERO = '0;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  handshake;

    assign handshake = (state == OUT) && out_ready;
    assign mem_addr  = cur_addr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (word_count == CNT_ZERO) ? FIN : ISSUE;
                end
            end
            ISSUE: state_next = WAIT;
            WAIT:  state_next = OUT;
            OUT: begin
                if (out_ready) begin
                    state_next = (remaining == CNT_ONE) ? FIN : ISSUE;
                end
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        mem_rd_en = (state == ISSUE);
        out_valid = (state == OUT);
    end

    // Read data arrives during WAIT and is captured together with its address,
    // so the output word stays frozen for as long as OUT is held off.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_addr  <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_addr  <= '0;
        end else begin
            if (state == IDLE && start && word_count != CNT_ZERO) begin
                cur_addr  <= base_addr;
                remaining <= word_count;
            end
            if (state == WAIT) begin
                out_data <= mem_rd_data;
                out_addr <= cur_addr;
            end
            if (handshake) begin
                remaining <= remaining - CNT_ONE;
                if (remaining != CNT_ONE) begin
                    cur_addr <= cur_addr + ADDR_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Scoreboard bench for mem_dump_reader: directed dumps push expected words,
// a negedge monitor pops and compares on every output handshake.
module tb_mem_dump_reader;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   word_count = '0;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;

    mem_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .word_count  (word_count),
        .busy        (busy),
        .done        (done),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr)
    );

    always #5 clock = ~clock;

    // RAM model: word i holds i*0x11111111, read data one cycle after the strobe
    logic [DW-1:0] ram [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = i * 32'h1111_1111;
    end
    always @(posedge clock) if (mem_rd_en) mem_rd_data <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            at_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   rd_count = 0;
    int   done_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: compares every accepted word against the scoreboard
    always @(negedge clock) begin
        if (mem_rd_en) rd_count++;
        if (done) done_count++;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got addr 0x%0h data 0x%0h, expected none", out_addr, out_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_addr", 64'(out_addr), 64'(e.addr));
                check("out_data", 64'(out_data), 64'(e.data));
                if (e.at_cyc >= 0) check("word_cycle", 64'(cyc), 64'(e.at_cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.at_cyc = c;
        exp_q.push_back(e);
    endtask

    // Pulses start for one edge; returns the cycle count at which start was raised
    task automatic start_dump(input logic [AW-1:0] b, input logic [AW:0] n, output int s);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        s          = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc);
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check("done_seen", 64'(seen), 64'd1);
        if (exp_cyc >= 0) check("done_cycle", 64'(cyc), 64'(exp_cyc));
        @(negedge clock);
        check("done_single", 64'(done), 64'd0);
        check("idle_after_done", 64'(busy), 64'd0);
        tick();
    endtask

    initial begin
        int s;
        int rd0;
        int dn0;
        logic [DW-1:0] hd;
        logic [AW-1:0] ha;
        bit got;

        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_addr", 64'(out_addr), 64'd0);
        reset = 1'b1;
        out_ready = 1'b1;
        tick();

        // Three words from address 2, ready held high
        rd0 = rd_count;
        start_dump(8'h02, 9'd3, s);
        expect_word(8'h02, 32'h2222_2222, s + 3);
        expect_word(8'h03, 32'h3333_3333, s + 6);
        expect_word(8'h04, 32'h4444_4444, s + 9);
        wait_done(s + 10);
        check("reads_3word", 64'(rd_count - rd0), 64'd3);

        // Address wrap at the top of the RAM
        start_dump(8'hFE, 9'd4, s);
        expect_word(8'hFE, 32'hEEEE_EEDE, s + 3);
        expect_word(8'hFF, 32'hFFFF_FFEF, s + 6);
        expect_word(8'h00, 32'h0000_0000, s + 9);
        expect_word(8'h01, 32'h1111_1111, s + 12);
        wait_done(s + 13);

        // Zero-length dump
        rd0 = rd_count;
        start_dump(8'h33, 9'd0, s);
        @(negedge clock);
        check("zero_busy", 64'(busy), 64'd1);
        check("zero_done", 64'(done), 64'd1);
        check("zero_valid", 64'(out_valid), 64'd0);
        @(negedge clock);
        check("zero_busy_after", 64'(busy), 64'd0);
        check("zero_reads", 64'(rd_count - rd0), 64'd0);
        tick();

        // Back-pressure: ready low for five cycles while a word is presented
        out_ready = 1'b0;
        rd0 = rd_count;
        start_dump(8'h05, 9'd2, s);
        expect_word(8'h05, 32'h5555_5555, -1);
        expect_word(8'h06, 32'h6666_6666, -1);
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clock);
            if (out_valid) got = 1;
        end
        check("bp_valid_seen", 64'(got), 64'd1);
        hd = out_data;
        ha = out_addr;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_valid_hold", 64'(out_valid), 64'd1);
            check("bp_data_hold", 64'(out_data), 64'(hd));
            check("bp_addr_hold", 64'(out_addr), 64'(ha));
            check("bp_no_read", 64'(mem_rd_en), 64'd0);
        end
        check("bp_reads_stalled", 64'(rd_count - rd0), 64'd1);
        tick();
        out_ready = 1'b1;
        wait_done(-1);

        // Reset during WAIT of a 4-word dump, with a start in the reset cycle
        dn0 = done_count;
        start_dump(8'h10, 9'd4, s);
        tick();
        reset      = 1'b0;
        start      = 1'b1;
        base_addr  = 8'h20;
        word_count = 9'd1;
        tick();
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rd_en", 64'(mem_rd_en), 64'd0);
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_mem_addr", 64'(mem_addr), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        check("abort_out_addr", 64'(out_addr), 64'd0);
        reset = 1'b1;
        tick();
        check("start_in_reset_ignored", 64'(busy), 64'd0);
        repeat (3) tick();
        check("abort_no_done", 64'(done_count - dn0), 64'd0);
        start_dump(8'h30, 9'd1, s);
        expect_word(8'h30, 32'h3333_3330, s + 3);
        wait_done(s + 4);

        // Start while busy must not disturb the running dump
        rd0 = rd_count;
        start_dump(8'h40, 9'd2, s);
        tick();
        start      = 1'b1;
        base_addr  = 8'h80;
        word_count = 9'd5;
        tick();
        start = 1'b0;
        expect_word(8'h40, 32'h4444_4440, s + 3);
        expect_word(8'h41, 32'h5555_5551, s + 6);
        wait_done(s + 7);
        repeat (3) tick();
        check("busy_start_ignored", 64'(busy), 64'd0);
        check("busy_start_reads", 64'(rd_count - rd0), 64'd2);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_dump_reader.md
MEM_DUMP_READER -- requirements
Module: mem_dump_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, SHALL set the word-address width of the RAM read port.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the RAM word width.
REQ-003 Port clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the synchronous, active-low reset; the block resets only on a rising clock edge with reset=0.
REQ-005 Port start  input  1  SHALL request a dump; sampled only in IDLE.
REQ-006 Port base_addr  input  ADDR_WIDTH  SHALL give the first word address; sampled with start.
REQ-007 Port word_count  input  ADDR_WIDTH+1  SHALL give the number of words to dump, range 0..2^ADDR_WIDTH; sampled with start.
REQ-008 Port busy  output  1  SHALL be 1 in every state except IDLE.
REQ-009 Port done  output  1  SHALL pulse high for exactly one cycle when a dump completes.
REQ-010 Port mem_rd_en  output  1  SHALL be the RAM read strobe.
REQ-011 Port mem_addr  output  ADDR_WIDTH  SHALL be the RAM word address.
REQ-012 Port mem_rd_data  input  DATA_WIDTH  SHALL be RAM read data, valid the cycle after mem_rd_en=1.
REQ-013 Port out_valid  output  1  SHALL flag a valid word on out_data/out_addr.
REQ-014 Port out_ready  input  1  SHALL be the downstream accept.
REQ-015 Port out_data  output  DATA_WIDTH  SHALL be the dumped word.
REQ-016 Port out_addr  output  ADDR_WIDTH  SHALL be the RAM address out_data was read from.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, OUT, FIN.
REQ-018 IDLE: start=1 with word_count>0 SHALL latch cur_addr=base_addr, remaining=word_count, go to ISSUE.
REQ-019 IDLE: start=1 with word_count=0 SHALL go to FIN with no RAM read and no out_valid.
REQ-020 ISSUE: SHALL assert mem_rd_en=1, mem_addr=cur_addr for exactly one cycle, then go to WAIT.
REQ-021 WAIT: SHALL register mem_rd_data into out_data and cur_addr into out_addr, then go to OUT.
REQ-022 OUT: out_valid SHALL be 1; out_data/out_addr SHALL stay stable until out_valid and out_ready are both 1.
REQ-023 OUT handshake with remaining=1 SHALL go to FIN; otherwise SHALL decrement remaining, increment cur_addr, go to ISSUE.
REQ-024 FIN: done SHALL be 1 for that single cycle, then go to IDLE.
REQ-025 cur_addr increment SHALL wrap modulo 2^ADDR_WIDTH (max address -> 0).
REQ-026 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-027 mem_rd_en SHALL be 0 in every state except ISSUE; mem_addr SHALL hold cur_addr.
REQ-028 Throughput SHALL be one word per 3 cycles when out_ready is held 1; latency start->first out_valid SHALL be 3 cycles (ISSUE, WAIT, then OUT).
REQ-029 out_ready while out_valid=0 SHALL have no effect.

Reset
REQ-030 reset=0 at a clock edge SHALL force IDLE, busy=0, done=0, mem_rd_en=0, out_valid=0, mem_addr=0, out_data=0, out_addr=0, remaining=0, in any state.
REQ-031 Reset mid-dump SHALL abort without a done pulse; the next start SHALL begin a fresh dump.
REQ-032 start asserted in the same cycle as reset=0 SHALL be ignored.

Verification
REQ-033 RAM[i]=i*0x11111111, base=2, count=3, out_ready=1 -> out_addr 2,3,4 with data 0x22222222, 0x33333333, 0x44444444, one word per 3 cycles, done pulse one cycle after last handshake.
REQ-034 base=0xFE, count=4 (ADDR_WIDTH=8) -> out_addr 0xFE, 0xFF, 0x00, 0x01.
REQ-035 count=0 -> no mem_rd_en, no out_valid, done one cycle after start, busy high only that cycle.
REQ-036 out_ready low for 5 cycles in OUT -> out_valid, out_data, out_addr held constant, no new mem_rd_en until handshake.
REQ-037 reset=0 asserted during WAIT of a 4-word dump -> next cycle all outputs 0, no done; subsequent start with count=1 dumps correctly.
REQ-038 start pulsed while busy with different base -> ignored; original dump completes unchanged.
